// File: rtl/mod_counter.sv
// Modulo-N up/down counter with synchronous clear/load, cascade terminal count,
// registered wrap pulse, load-rejection pulse and optional two-digit BCD image.
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6,
  parameter int INIT    = 0,
  parameter int BCD_OUT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_out,
  output logic [7:0]       o_bcd,
  output logic             o_tc,
  output logic             o_carry,
  output logic             o_load_err
);

  localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   L_MOD  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] L_INIT = WIDTH'(INIT);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_load_err;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_ok;
  logic             w_wrap;

  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 32'(v);
    return {4'(n / 32'd10), 4'(n % 32'd10)};
  endfunction

  assign w_at_max  = (r_out == L_MAX);
  assign w_at_zero = (r_out == '0);
  // Widened compare so the check also works when MODULUS == 2**WIDTH.
  assign w_load_ok = ({1'b0, i_load_val} < L_MOD);
  assign w_wrap    = i_up ? w_at_max : w_at_zero;
  assign o_tc      = i_en & ~i_clr & ~i_load & w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out      <= L_INIT;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else if (i_clr) begin
      r_out      <= '0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else if (i_load) begin
      if (w_load_ok) begin
        r_out <= i_load_val;
      end else begin
        r_out <= r_out;
      end
      r_carry    <= 1'b0;
      r_load_err <= ~w_load_ok;
    end else if (i_en) begin
      if (i_up) begin
        r_out <= w_at_max ? '0 : r_out + WIDTH'(1);
      end else begin
        r_out <= w_at_zero ? L_MAX : r_out - WIDTH'(1);
      end
      r_carry    <= w_wrap;
      r_load_err <= 1'b0;
    end else begin
      r_out      <= r_out;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign o_out      = r_out;
  assign o_carry    = r_carry;
  assign o_load_err = r_load_err;

  generate
    if (BCD_OUT != 0) begin : g_bcd
      assign o_bcd = to_bcd(r_out);
    end else begin : g_no_bcd
      assign o_bcd = 8'h00;
    end
  endgenerate

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: default instance, small-modulus instances
// (INIT/reset and 2**WIDTH wrap) and a two-stage BCD cascade.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Group A: default instance
  logic       a_rst_n = 1'b0, a_en = 1'b0, a_up = 1'b1, a_clr = 1'b0, a_load = 1'b0;
  logic [5:0] a_lv = 6'd0;
  logic [5:0] a_out;
  logic [7:0] a_bcd;
  logic       a_tc, a_carry, a_lerr;

  mod_counter u_dut (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_en(a_en), .i_up(a_up), .i_clr(a_clr),
    .i_load(a_load), .i_load_val(a_lv), .o_out(a_out), .o_bcd(a_bcd),
    .o_tc(a_tc), .o_carry(a_carry), .o_load_err(a_lerr)
  );

  // Group B: MODULUS=21 with INIT=7, and MODULUS=8=2**WIDTH, shared stimulus
  logic       b_rst_n = 1'b0, b_en = 1'b0, b_up = 1'b1, b_clr = 1'b0, b_load = 1'b0;
  logic [4:0] b_lv = 5'd0;
  logic [4:0] m_out;
  logic [2:0] p_out;
  logic [7:0] m_bcd, p_bcd;
  logic       m_tc, m_carry, m_lerr, p_tc, p_carry, p_lerr;

  mod_counter #(.MODULUS(21), .WIDTH(5), .INIT(7), .BCD_OUT(0)) u_m21 (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .i_up(b_up), .i_clr(b_clr),
    .i_load(b_load), .i_load_val(b_lv), .o_out(m_out), .o_bcd(m_bcd),
    .o_tc(m_tc), .o_carry(m_carry), .o_load_err(m_lerr)
  );

  mod_counter #(.MODULUS(8), .WIDTH(3), .INIT(0), .BCD_OUT(0)) u_p2 (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_en(b_en), .i_up(b_up), .i_clr(b_clr),
    .i_load(b_load), .i_load_val(b_lv[2:0]), .o_out(p_out), .o_bcd(p_bcd),
    .o_tc(p_tc), .o_carry(p_carry), .o_load_err(p_lerr)
  );

  // Group C: two-stage cascade, stage 2 enabled by stage 1 terminal count
  logic       c_rst_n = 1'b0, c_en = 1'b0;
  logic [5:0] s1_out, s2_out;
  logic [7:0] s1_bcd, s2_bcd;
  logic       s1_tc, s1_carry, s1_lerr, s2_tc, s2_carry, s2_lerr;

  mod_counter #(.MODULUS(60), .WIDTH(6), .INIT(0), .BCD_OUT(1)) u_s1 (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_en(c_en), .i_up(1'b1), .i_clr(1'b0),
    .i_load(1'b0), .i_load_val(6'd0), .o_out(s1_out), .o_bcd(s1_bcd),
    .o_tc(s1_tc), .o_carry(s1_carry), .o_load_err(s1_lerr)
  );

  mod_counter #(.MODULUS(60), .WIDTH(6), .INIT(0), .BCD_OUT(1)) u_s2 (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_en(s1_tc), .i_up(1'b1), .i_clr(1'b0),
    .i_load(1'b0), .i_load_val(6'd0), .o_out(s2_out), .o_bcd(s2_bcd),
    .o_tc(s2_tc), .o_carry(s2_carry), .o_load_err(s2_lerr)
  );

  initial begin
    int exp_v;
    int carries;

    // ---------------- Group A ----------------
    #2;
    chk("a_rst_out", 32'(a_out), 32'd0);
    chk("a_rst_carry", 32'(a_carry), 32'd0);
    chk("a_rst_lerr", 32'(a_lerr), 32'd0);
    chk("a_bcd_off", 32'(a_bcd), 32'h00);
    @(negedge clk);
    a_rst_n = 1'b1;
    a_en = 1'b1;
    a_up = 1'b1;
    exp_v = 0;
    carries = 0;
    for (int i = 1; i <= 61; i++) begin
      #1 chk("a_up_tc", 32'(a_tc), (exp_v == 59) ? 32'd1 : 32'd0);
      tick();
      exp_v = (exp_v + 1) % 60;
      chk("a_up_out", 32'(a_out), 32'(exp_v));
      chk("a_up_carry", 32'(a_carry), (i == 60) ? 32'd1 : 32'd0);
      if (a_carry) carries++;
    end
    chk("a_up_ncarry", 32'(carries), 32'd1);
    a_en = 1'b0;
    tick();
    chk("a_hold_out", 32'(a_out), 32'd1);
    chk("a_hold_carry", 32'(a_carry), 32'd0);

    // Down count from 0 wraps to 59, then direction change on the same edge
    a_rst_n = 1'b0;
    #2 a_rst_n = 1'b1;
    chk("a_rst2_out", 32'(a_out), 32'd0);
    a_up = 1'b0;
    a_en = 1'b1;
    #1 chk("a_dn_tc", 32'(a_tc), 32'd1);
    tick();
    chk("a_dn_out59", 32'(a_out), 32'd59);
    chk("a_dn_carry", 32'(a_carry), 32'd1);
    tick();
    chk("a_dn_out58", 32'(a_out), 32'd58);
    chk("a_dn_carry0", 32'(a_carry), 32'd0);
    a_up = 1'b1;
    tick();
    chk("a_dir_out59", 32'(a_out), 32'd59);
    tick();
    chk("a_dir_out0", 32'(a_out), 32'd0);
    chk("a_dir_carry", 32'(a_carry), 32'd1);

    // Loads: accepted, rejected (60 and 63), boundary 59
    a_en = 1'b0;
    a_load = 1'b1;
    a_lv = 6'd45;
    tick();
    chk("a_ld45_out", 32'(a_out), 32'd45);
    chk("a_ld45_err", 32'(a_lerr), 32'd0);
    a_lv = 6'd60;
    tick();
    chk("a_ld60_out", 32'(a_out), 32'd45);
    chk("a_ld60_err", 32'(a_lerr), 32'd1);
    a_load = 1'b0;
    tick();
    chk("a_lderr_pulse", 32'(a_lerr), 32'd0);
    chk("a_lderr_out", 32'(a_out), 32'd45);
    a_load = 1'b1;
    a_lv = 6'd63;
    tick();
    chk("a_ld63_out", 32'(a_out), 32'd45);
    chk("a_ld63_err", 32'(a_lerr), 32'd1);
    a_lv = 6'd59;
    a_en = 1'b1;
    tick();
    chk("a_ld59_out", 32'(a_out), 32'd59);
    chk("a_ld59_err", 32'(a_lerr), 32'd0);
    #1 chk("a_tc_load_mask", 32'(a_tc), 32'd0);

    // Priority: clr over load over en
    a_lv = 6'd30;
    a_en = 1'b0;
    tick();
    chk("a_ld30_out", 32'(a_out), 32'd30);
    a_clr = 1'b1;
    a_load = 1'b1;
    a_en = 1'b1;
    a_lv = 6'd10;
    tick();
    chk("a_clr_prio", 32'(a_out), 32'd0);
    chk("a_clr_carry", 32'(a_carry), 32'd0);
    a_clr = 1'b0;
    a_lv = 6'd30;
    tick();
    a_lv = 6'd10;
    tick();
    chk("a_load_prio", 32'(a_out), 32'd10);
    a_load = 1'b0;
    a_en = 1'b0;

    // ---------------- Group B ----------------
    #1;
    chk("m_init", 32'(m_out), 32'd7);
    chk("p_init", 32'(p_out), 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    b_up = 1'b1;
    b_en = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 8) begin
        chk("p_wrap_out", 32'(p_out), 32'd0);
        chk("p_wrap_carry", 32'(p_carry), 32'd1);
      end
      if (i == 13) chk("m_max", 32'(m_out), 32'd20);
    end
    chk("m_wrap_out", 32'(m_out), 32'd0);
    chk("m_wrap_carry", 32'(m_carry), 32'd1);
    chk("p_after14", 32'(p_out), 32'd6);
    b_en = 1'b0;
    b_load = 1'b1;
    b_lv = 5'd7;
    tick();
    chk("m_ld7", 32'(m_out), 32'd7);
    chk("p_ld7", 32'(p_out), 32'd7);
    chk("p_ld7_err", 32'(p_lerr), 32'd0);
    b_lv = 5'd21;
    tick();
    chk("m_ld21_out", 32'(m_out), 32'd7);
    chk("m_ld21_err", 32'(m_lerr), 32'd1);
    chk("p_ld5_out", 32'(p_out), 32'd5);
    chk("p_ld5_err", 32'(p_lerr), 32'd0);
    b_load = 1'b0;
    b_clr = 1'b1;
    tick();
    chk("m_clr", 32'(m_out), 32'd0);
    chk("m_clr_err", 32'(m_lerr), 32'd0);
    b_clr = 1'b0;
    b_up = 1'b0;
    b_en = 1'b1;
    tick();
    chk("m_dn_out", 32'(m_out), 32'd20);
    chk("m_dn_carry", 32'(m_carry), 32'd1);
    chk("p_dn_out", 32'(p_out), 32'd7);
    // Asynchronous reset between edges while out=20 and carry=1
    b_rst_n = 1'b0;
    #2;
    chk("m_arst_out", 32'(m_out), 32'd7);
    chk("m_arst_carry", 32'(m_carry), 32'd0);
    chk("p_arst_out", 32'(p_out), 32'd0);
    chk("p_arst_carry", 32'(p_carry), 32'd0);
    #1 b_rst_n = 1'b1;
    tick();
    chk("m_first_edge", 32'(m_out), 32'd6);
    chk("p_first_edge", 32'(p_out), 32'd7);
    chk("p_first_carry", 32'(p_carry), 32'd1);
    b_en = 1'b0;

    // ---------------- Group C ----------------
    @(negedge clk);
    c_rst_n = 1'b1;
    c_en = 1'b1;
    for (int i = 1; i <= 3600; i++) begin
      if (i == 3600) #1 chk("s2_tc_last", 32'(s2_tc), 32'd1);
      tick();
      if (i == 47) begin
        chk("s1_bcd47", 32'(s1_bcd), 32'h47);
        chk("s2_at47", 32'(s2_out), 32'd0);
      end
      if (i == 60) begin
        chk("s1_at60", 32'(s1_out), 32'd0);
        chk("s2_at60", 32'(s2_out), 32'd1);
        chk("s2_bcd01", 32'(s2_bcd), 32'h01);
      end
      if (i == 3599) begin
        chk("s1_at3599", 32'(s1_out), 32'd59);
        chk("s2_at3599", 32'(s2_out), 32'd59);
        chk("s2_bcd59", 32'(s2_bcd), 32'h59);
      end
    end
    chk("s1_end", 32'(s1_out), 32'd0);
    chk("s2_end", 32'(s2_out), 32'd0);
    chk("s1_end_carry", 32'(s1_carry), 32'd1);
    chk("s2_end_carry", 32'(s2_carry), 32'd1);
    chk("s_lerr", 32'({s1_lerr, s2_lerr}), 32'd0);
    c_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 60: count range 0..MODULUS-1; legal values 2..2**WIDTH.
REQ-002 SHALL have parameter WIDTH, default 6: count register width.
REQ-003 SHALL have parameter INIT, default 0: reset value of count; legal values 0..MODULUS-1.
REQ-004 SHALL have parameter BCD_OUT, default 0: when 1, bcd port carries a two-digit BCD image of count; legal only with MODULUS<=100.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  count enable / carry-in from the lower cascade stage.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 clr  input  1  synchronous clear to 0.
REQ-010 load  input  1  synchronous load request.
REQ-011 load_val  input  WIDTH  value applied on load.
REQ-012 out  output  WIDTH  current count, registered.
REQ-013 bcd  output  8  {tens, units} BCD of out; constant 8'h00 when BCD_OUT=0.
REQ-014 tc  output  1  combinational terminal count for synchronous cascading.
REQ-015 carry  output  1  registered one-cycle wrap/borrow pulse.
REQ-016 load_err  output  1  registered one-cycle pulse on rejected load.

Function
REQ-017 Per-edge priority SHALL be: clr, then load, then en; lower-priority requests in the same cycle are ignored.
REQ-018 clr=1: out<=0, carry<=0, load_err<=0.
REQ-019 load=1, clr=0, load_val<MODULUS: out<=load_val, carry<=0, load_err<=0.
REQ-020 load=1, clr=0, load_val>=MODULUS: out unchanged, carry<=0, load_err<=1 for exactly one cycle.
REQ-021 en=1, up=1, no clr/load: out<=out+1; at out==MODULUS-1, out<=0 and carry<=1.
REQ-022 en=1, up=0, no clr/load: out<=out-1; at out==0, out<=MODULUS-1 and carry<=1.
REQ-023 Otherwise out SHALL hold, and carry and load_err SHALL be 0.
REQ-024 carry SHALL be high only in the cycle immediately after the wrapping edge, i.e. coincident with out showing the wrapped value (0 when counting up, MODULUS-1 when counting down).
REQ-025 tc SHALL equal en & ~clr & ~load & (up ? out==MODULUS-1 : out==0), with no register delay, so that tc can drive the next stage's en for a same-edge rollover.
REQ-026 A direction change SHALL take effect on the same edge; there is no pipeline.
REQ-027 Arithmetic SHALL be performed in WIDTH bits, and out SHALL never leave 0..MODULUS-1, including when MODULUS=2**WIDTH.
REQ-028 bcd SHALL be combinational from out: tens=out/10, units=out%10, each 4 bits.
REQ-029 Continuous en=1 counting up SHALL produce exactly one carry pulse per MODULUS enabled cycles.

Reset
REQ-030 While reset=0, asynchronously: out=INIT, carry=0, load_err=0, regardless of clk.
REQ-031 A reset asserted mid-count or mid-pulse SHALL clear carry and load_err immediately.
REQ-032 The first edge after reset release SHALL be processed normally per REQ-017..REQ-023.

Verification
REQ-033 Defaults, up=1, en=1 for 61 edges from reset -> out 0..59, 0, 1; carry=1 only in the cycle out first returns to 0.
REQ-034 Defaults, up=0, en=1 from reset -> out goes 0 to 59 with carry=1 in that cycle, then 58.
REQ-035 Defaults: load=1 with load_val=45 -> out=45, load_err=0; load=1 with load_val=60 -> out stays 45, load_err pulses for 1 cycle.
REQ-036 Defaults: clr=1, load=1, en=1 together at out=30 -> out=0; load=1, en=1 at out=30, load_val=10 -> out=10.
REQ-037 Two instances (MODULUS=60, BCD_OUT=1), stage-2 en = stage-1 tc, 3600 enabled edges -> both stages return to 0 on the same edge; bcd of stage 1 at out=47 is 8'h47.
REQ-038 Reset pulsed low asynchronously between edges while out=20 and carry=1 -> out=INIT and carry=0 immediately, with no clk edge required.
